seq_alu: RTL and testbench

Parametrised, handshaked multi-function ALU. It generalises the team's combinational 3-bit-opcode ALU to WIDTH-bit operands, a 4-bit opcode, signed/unsigned compares, three shift kinds and an optional multi-cycle multiplier. Results and flags are registered. Operands arrive from the datapath through a valid/ready handshake, and results leave through a second valid/ready handshake towards the writeback stage.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/seq_mul_unit.sv | 85 ++++++++
 rtl/seq_alu.sv | 217 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the handshaked sequential ALU (seq_alu) and its
// shift-add multiplier (seq_mul_unit).
//   alu_op_e    : 4-bit opcode encoding (12..15 are unimplemented)
//   alu_state_e : handshake FSM states
//   alu_flags_t : registered flag bundle
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_NOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic neg;
        logic illegal;
    } alu_flags_t;

    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// -----------------------------------------------------------------------------
// seq_mul_unit
// Shift-add multiplier, one bit of b per cycle, LSB first. Produces the low
// WIDTH bits of a*b.
//   clk, rst_n : clock, async active-low reset
//   start      : capture a/b and begin (ignored bits of a/b afterwards)
//   a, b       : operands
//   busy       : multiplication in progress
//   done       : combinational, high on the last step; product is final then
//   product    : running sum including the current step's partial product
// -----------------------------------------------------------------------------
module seq_mul_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] partial;

    // product already includes the bit being processed this cycle, so the
    // final value is available on the same edge that finishes the last step.
    assign partial = b_q[0] ? a_q : '0;
    assign product = acc_q + partial;
    assign done    = busy_q && (cnt_q == CNT_LAST);
    assign busy    = busy_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = product;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            if (done) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked multi-function ALU with registered result and flags.
// States:
//   ST_IDLE | waiting for an operand handshake, in_ready = 1
//   ST_MUL  | multi-cycle multiply in progress, in_ready = 0
//   ST_DONE | result valid, held until out_ready; may accept the next op
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : operand handshake (alu_op, data_a, data_b)
//   out_valid/out_ready        : result handshake
//   result                     : registered result
//   zero/carry/overflow/neg    : registered flags
//   illegal_op                 : opcode outside the supported set
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             neg_flag,
    output logic             illegal_op
);

    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    logic             accept;
    logic             is_mul_op;
    logic             load_alu;
    logic             load_mul;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    alu_flags_t       alu_flg;
    alu_flags_t       mul_flg;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             shift_oor;
    logic [SH_W-1:0]  shamt;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul_op = op_is_mul(alu_op) && MUL_EN;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign sum_ext   = {1'b0, data_a} + {1'b0, data_b};
    // Bit WIDTH of the extended difference is the unsigned borrow (A < B).
    assign diff_ext  = {1'b0, data_a} - {1'b0, data_b};
    // The full A is compared so that large shift amounts saturate rather
    // than wrapping through the truncated shift count.
    assign shift_oor = (data_a >= WIDTH_V);
    assign shamt     = data_a[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_flg = '0;
        case (alu_op)
            OP_AND:  alu_res = data_a & data_b;
            OP_OR:   alu_res = data_a | data_b;
            OP_XOR:  alu_res = data_a ^ data_b;
            OP_NOR:  alu_res = ~(data_a | data_b);
            OP_ADD: begin
                alu_res          = sum_ext[WIDTH-1:0];
                alu_flg.carry    = sum_ext[WIDTH];
                alu_flg.overflow = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                                   (sum_ext[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res          = diff_ext[WIDTH-1:0];
                alu_flg.carry    = diff_ext[WIDTH];
                alu_flg.overflow = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                                   (diff_ext[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
            OP_SLL:  alu_res = shift_oor ? '0 : (data_b << shamt);
            OP_SRL:  alu_res = shift_oor ? '0 : (data_b >> shamt);
            OP_SRA:  alu_res = shift_oor ? {WIDTH{data_b[WIDTH-1]}}
                                         : WIDTH'($signed(data_b) >>> shamt);
            // Only reached as a single-cycle op when the multiplier is not
            // built; with MUL_EN the result comes from seq_mul_unit instead.
            OP_MUL:  alu_flg.illegal = 1'b1;
            default: alu_flg.illegal = 1'b1;
        endcase
        if (alu_flg.illegal) begin
            alu_res = '0;
        end
        alu_flg.zero = (alu_res == '0);
        alu_flg.neg  = alu_res[WIDTH-1];
    end

    always_comb begin
        mul_flg      = '0;
        mul_flg.zero = (mul_product == '0);
        mul_flg.neg  = mul_product[WIDTH-1];
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    if (MUL_EN) begin : g_mul
        seq_mul_unit #(
            .WIDTH (WIDTH)
        ) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (mul_start),
            .a       (data_a),
            .b       (data_b),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_product)
        );
    end else begin : g_no_mul
        assign mul_busy    = 1'b0;
        assign mul_done    = 1'b0;
        assign mul_product = '0;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE without out_ready holds; otherwise behave as IDLE.
                if ((state_q == ST_IDLE) || out_ready) begin
                    if (accept) begin
                        if (is_mul_op) begin
                            state_d   = ST_MUL;
                            mul_start = 1'b1;
                        end else begin
                            state_d  = ST_DONE;
                            load_alu = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    load_mul = 1'b1;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; do not wait forever.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (load_alu) begin
            result_d = alu_res;
            flags_d  = alu_flg;
        end else if (load_mul) begin
            result_d = mul_product;
            flags_d  = mul_flg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result        = result_q;
    assign zero_flag     = flags_q.zero;
    assign carry_flag    = flags_q.carry;
    assign overflow_flag = flags_q.overflow;
    assign neg_flag      = flags_q.neg;
    assign illegal_op    = flags_q.illegal;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero_flag;
    logic        carry_flag;
    logic        overflow_flag;
    logic        neg_flag;
    logic        illegal_op;

    int passed;
    int total;

    seq_alu #(
        .WIDTH  (32),
        .MUL_EN (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_op        (alu_op),
        .data_a        (data_a),
        .data_b        (data_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .neg_flag      (neg_flag),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one operation for one edge, then drop in_valid; leaves time at
    // posedge+1 so outputs can be sampled.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 4'd0;
        data_a    = '0;
        data_b    = '0;
        #12;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 0", result); else passed++;
        total++;
        if ({zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op} !== 5'b0)
            $display("FAIL reset_flags got %b exp 00000",
                     {zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        alu_op = 4'd4; data_a = 32'h7FFF_FFFF; data_b = 32'h7FFF_FFFF; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL add_in_ready got %b exp 1", in_ready); else passed++;
        do_op(4'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        total++; if (out_valid !== 1'b1) $display("FAIL add_latency out_valid got %b exp 1", out_valid); else passed++;
        total++; if (result !== 32'hFFFF_FFFE) $display("FAIL add_result got %h exp fffffffe", result); else passed++;
        total++;
        if ({zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op} !== 5'b00110)
            $display("FAIL add_flags got %b exp 00110",
                     {zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op});
        else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL add_drain out_valid got %b exp 0", out_valid); else passed++;
        // Unsigned carry without signed overflow.
        do_op(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
        total++;
        if ({result, zero_flag, carry_flag, overflow_flag} !== {32'h0, 3'b110})
            $display("FAIL add_carry got %h z%b c%b v%b exp 0 z1 c1 v0",
                     result, zero_flag, carry_flag, overflow_flag);
        else passed++;
    endtask

    task automatic test_sub_cmp();
        do_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        total++; if (result !== 32'h8000_0001) $display("FAIL sub_result got %h exp 80000001", result); else passed++;
        total++;
        if ({carry_flag, overflow_flag, neg_flag} !== 3'b101)
            $display("FAIL sub_flags got c%b v%b n%b exp c1 v0 n1", carry_flag, overflow_flag, neg_flag);
        else passed++;
        do_op(4'd5, 32'h8000_0000, 32'h0000_0001);
        total++;
        if ({result, carry_flag, overflow_flag} !== {32'h7FFF_FFFF, 2'b01})
            $display("FAIL sub_ovf got %h c%b v%b exp 7fffffff c0 v1", result, carry_flag, overflow_flag);
        else passed++;
        do_op(4'd6, 32'h8000_0000, 32'h0000_0001);
        total++; if (result !== 32'h1) $display("FAIL slt_result got %h exp 1", result); else passed++;
        do_op(4'd7, 32'h8000_0000, 32'h0000_0001);
        total++;
        if ({result, zero_flag} !== {32'h0, 1'b1})
            $display("FAIL sltu_result got %h z%b exp 0 z1", result, zero_flag);
        else passed++;
    endtask

    task automatic test_logic();
        logic [3:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3};
        exp = '{32'h000F_000F, 32'h0FFF_0FFF, 32'h0FF0_0FF0, 32'hF000_F000};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], 32'h0F0F_00FF, 32'h00FF_0F0F);
            total++;
            if ({result, neg_flag} !== {exp[i], exp[i][31]})
                $display("FAIL logic_op%0d got %h n%b exp %h", ops[i], result, neg_flag, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [5];
        logic [31:0] av  [5];
        logic [31:0] bv  [5];
        logic [31:0] exp [5];
        ops = '{4'd8,  4'd10,        4'd9,         4'd8,  4'd10};
        av  = '{32'd32, 32'd40,      32'd31,       32'd4, 32'd4};
        bv  = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h8000_0000};
        exp = '{32'h0, 32'hFFFF_FFFF, 32'h1,       32'h10, 32'hF800_0000};
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], av[i], bv[i]);
            total++;
            if (result !== exp[i])
                $display("FAIL shift_op%0d_a%0d got %h exp %h", ops[i], av[i], result, exp[i]);
            else passed++;
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int   cyc;
        logic ready_seen;
        do_op(4'd11, a, b);
        // Operands change after accept; the multiplier must ignore them.
        data_a     = 32'h5555_5555;
        data_b     = 32'h1234_5678;
        cyc        = 0;
        ready_seen = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (cyc !== 32) $display("FAIL mul_latency got %0d exp 32", cyc); else passed++;
        total++; if (ready_seen !== 1'b0) $display("FAIL mul_in_ready got 1 exp 0"); else passed++;
        total++; if (result !== exp) $display("FAIL mul_result got %h exp %h", result, exp); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_mul(32'h3, 32'h607, 32'h1215);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        do_op(4'd4, 32'h1, 32'h2);
        // Offer a different op during the stall; it must not be taken.
        in_valid = 1'b1; alu_op = 4'd5; data_a = 32'h0; data_b = 32'h9;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, result, zero_flag, carry_flag, neg_flag} !== {2'b10, 32'h3, 3'b000})
                $display("FAIL stall_cyc%0d got v%b r%b %h z%b c%b n%b exp v1 r0 3",
                         i, out_valid, in_ready, result, zero_flag, carry_flag, neg_flag);
            else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        alu_op = 4'd2; data_a = 32'hF0; data_b = 32'hFF;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b exp 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, result} !== {1'b1, 32'h0F})
            $display("FAIL b2b_xor got v%b %h exp v1 0000000f", out_valid, result);
        else passed++;
        do_op(4'd1, 32'h100, 32'h1);
        total++; if (result !== 32'h101) $display("FAIL b2b_or got %h exp 00000101", result); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        do_op(4'd13, 32'h5, 32'h6);
        total++;
        if ({result, zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op} !== {32'h0, 5'b10001})
            $display("FAIL illegal_op13 got %h flags %b exp 0 flags 10001", result,
                     {zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op});
        else passed++;
        do_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++; if ({out_valid, illegal_op} !== 2'b11) $display("FAIL illegal_op15 got v%b i%b exp v1 i1", out_valid, illegal_op); else passed++;
        do_op(4'd4, 32'h0, 32'h0);
        total++; if ({zero_flag, illegal_op} !== 2'b10) $display("FAIL illegal_clear got z%b i%b exp z1 i0", zero_flag, illegal_op); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        do_op(4'd5, 32'h1, 32'h2);
        @(posedge clk); #1;
        do_op(4'd11, 32'h7, 32'h9);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, result, zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op} !== {2'b10, 32'h0, 5'b0})
            $display("FAIL mid_mul_reset got r%b v%b %h flags %b exp r1 v0 0 00000", in_ready, out_valid, result,
                     {zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                total++;
                $display("FAIL stale_out_valid at cycle %0d got 1 exp 0", i);
                break;
            end
        end
        do_op(4'd4, 32'h5, 32'h7);
        total++;
        if ({out_valid, result} !== {1'b1, 32'd12})
            $display("FAIL post_reset_add got v%b %h exp v1 0000000c", out_valid, result);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_logic();
        test_shifts();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
